seven_seg_reader: RTL and testbench



---
 rtl/seven_seg_reader_pkg.sv | 45 ++++
 rtl/seven_seg_reader_if.sv | 26 ++
 rtl/seven_seg_pattern_decode.sv | 37 +++
 rtl/seven_seg_reader.sv | 134 +++++++++++++
 tb/tb_seven_seg_reader.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/seven_seg_reader_pkg.sv
// Shared constants and types for the seven-segment bus reader.
// Optional hex A..F decode: define SEVSEG_RD_HEXAF_EN.
package seven_seg_pkg;

  localparam int DEF_NUM_DIGITS = 4;

  localparam int SEG_BIT_A = 6;
  localparam int SEG_BIT_B = 5;
  localparam int SEG_BIT_C = 4;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 2;
  localparam int SEG_BIT_F = 1;
  localparam int SEG_BIT_G = 0;

  localparam logic [6:0] SEG_0 = 7'h01;
  localparam logic [6:0] SEG_1 = 7'h4F;
  localparam logic [6:0] SEG_2 = 7'h12;
  localparam logic [6:0] SEG_3 = 7'h06;
  localparam logic [6:0] SEG_4 = 7'h4C;
  localparam logic [6:0] SEG_5 = 7'h24;
  localparam logic [6:0] SEG_6 = 7'h20;
  localparam logic [6:0] SEG_7 = 7'h0F;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h04;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h60;
  localparam logic [6:0] SEG_C = 7'h31;
  localparam logic [6:0] SEG_D = 7'h42;
  localparam logic [6:0] SEG_E = 7'h30;
  localparam logic [6:0] SEG_F = 7'h38;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } dec_t;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/seven_seg_reader_if.sv
// Snooped display bus plus recovered frame outputs.
// slave = reader, master = display driver / observer.
interface seven_seg_reader_if
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
);
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   err_mask;
  logic                    frame_valid;

  modport master (
    output seg, an,
    input  value, blank_mask,
    input  err_mask, frame_valid
  );

  modport slave (
    input  seg, an,
    output value, blank_mask,
    output err_mask, frame_valid
  );
endinterface

// File: rtl/seven_seg_pattern_decode.sv
// Active-low 7-segment pattern back to nibble/blank/err.
// Hex A..F accepted only with SEVSEG_RD_HEXAF_EN.
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output dec_t       dec
);

  // Table lookup; unknown patterns flag err, nibble 0
  always_comb begin
    dec = '{nibble: 4'h0, blank: 1'b0, err: 1'b0};
    unique case (1'b1)
      (pattern == SEG_0):     dec.nibble = 4'h0;
      (pattern == SEG_1):     dec.nibble = 4'h1;
      (pattern == SEG_2):     dec.nibble = 4'h2;
      (pattern == SEG_3):     dec.nibble = 4'h3;
      (pattern == SEG_4):     dec.nibble = 4'h4;
      (pattern == SEG_5):     dec.nibble = 4'h5;
      (pattern == SEG_6):     dec.nibble = 4'h6;
      (pattern == SEG_7):     dec.nibble = 4'h7;
      (pattern == SEG_8):     dec.nibble = 4'h8;
      (pattern == SEG_9):     dec.nibble = 4'h9;
      (pattern == SEG_BLANK): dec.blank  = 1'b1;
`ifdef SEVSEG_RD_HEXAF_EN
      (pattern == SEG_A):     dec.nibble = 4'hA;
      (pattern == SEG_B):     dec.nibble = 4'hB;
      (pattern == SEG_C):     dec.nibble = 4'hC;
      (pattern == SEG_D):     dec.nibble = 4'hD;
      (pattern == SEG_E):     dec.nibble = 4'hE;
      (pattern == SEG_F):     dec.nibble = 4'hF;
`endif
      default:                dec.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Recovers hex digits from a multiplexed 7-seg bus.
// Optional hex A..F decode: define SEVSEG_RD_HEXAF_EN.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
  parameter int STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  seven_seg_reader_if.slave bus
);

  localparam logic [7:0] STB = 8'(STABLE_CYCLES);

  logic [6:0]            seg_q;
  logic [6:0]            seg_p;
  logic [NUM_DIGITS-1:0] an_q;
  logic [NUM_DIGITS-1:0] an_p;
  state_t                state;
  logic [7:0]            cnt;
  logic [7:0]            cnt_inc;
  logic                  valid;
  logic                  same;
  logic                  capture;
  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] sh_blank;
  logic [NUM_DIGITS-1:0] sh_err;
  logic [NUM_DIGITS-1:0][3:0] sh_nib;
  dec_t                  dec;

  seven_seg_pattern_decode u_dec (
    .pattern (seg_q),
    .dec     (dec)
  );

  // Capture bus once, and keep the previous sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '1;
      seg_p <= '1;
      an_q  <= '1;
      an_p  <= '1;
    end else begin
      seg_q <= bus.seg;
      an_q  <= bus.an;
      seg_p <= seg_q;
      an_p  <= an_q;
    end
  end

  // Anode check, sample compare, capture strobe
  always_comb begin
    valid   = ($countones(~an_q) == 1);
    sel     = valid ? ~an_q : '0;
    same    = (seg_q == seg_p) && (an_q == an_p);
    cnt_inc = (cnt >= STB) ? cnt : cnt + 8'd1;
    capture = valid && same &&
              (state == SETTLE) &&
              (cnt_inc == STB);
  end

  // Stability FSM; counter saturates at STB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      cnt   <= '0;
    end else if (!valid) begin
      state <= WAIT;
      cnt   <= '0;
    end else begin
      unique case (state)
        WAIT: begin
          state <= SETTLE;
          cnt   <= 8'd1;
        end
        SETTLE: begin
          if (!same) begin
            cnt <= 8'd1;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == STB) state <= HELD;
          end
        end
        HELD: begin
          if (!same) begin
            state <= SETTLE;
            cnt   <= 8'd1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Shadow slots, seen mask, frame publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen            <= '0;
      sh_nib          <= '0;
      sh_blank        <= '0;
      sh_err          <= '0;
      bus.value       <= '0;
      bus.blank_mask  <= '0;
      bus.err_mask    <= '0;
      bus.frame_valid <= 1'b0;
    end else begin
      bus.frame_valid <= &seen;
      if (&seen) begin
        bus.value      <= sh_nib;
        bus.blank_mask <= sh_blank;
        bus.err_mask   <= sh_err;
      end
      seen <= ((&seen) ? '0 : seen) |
              (capture ? sel : '0);
      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            sh_nib[i]   <= dec.nibble;
            sh_blank[i] <= dec.blank;
            sh_err[i]   <= dec.err;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader.
// Build with +define+SEVSEG_RD_HEXAF_EN for hex A..F.
module tb_seven_seg_reader;
  import seven_seg_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   frames;
  int   wide;
  logic prev_fv;
  logic mon8;
  logic bad8;
  int   f0;

  seven_seg_reader_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_reader #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    prev_fv <= bus.frame_valid;
    if (bus.frame_valid) begin
      frames <= frames + 1;
      if (prev_fv) wide <= wide + 1;
      if (mon8 && bus.value[3:0] == 4'h8)
        bad8 <= 1'b1;
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    else
      passed++;
  endtask

  task automatic show(
    input logic [3:0] a,
    input logic [6:0] s,
    input int         n
  );
    bus.an  = a;
    bus.seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    show(4'b1111, SEG_BLANK, n);
  endtask

  task automatic scan4(
    input logic [6:0] s0,
    input logic [6:0] s1,
    input logic [6:0] s2,
    input logic [6:0] s3
  );
    show(4'b1110, s0, 6);
    show(4'b1101, s1, 6);
    show(4'b1011, s2, 6);
    show(4'b0111, s3, 6);
    idle(4);
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    frames  = 0;
    wide    = 0;
    prev_fv = 1'b0;
    mon8    = 1'b0;
    bad8    = 1'b0;
    rst_n   = 1'b0;
    bus.an  = 4'b1111;
    bus.seg = SEG_BLANK;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(bus.value), 32'h0);
    check("rst_blank", 32'(bus.blank_mask), 32'h0);
    check("rst_err", 32'(bus.err_mask), 32'h0);
    check("rst_fv", 32'(bus.frame_valid), 32'h0);
    rst_n = 1'b1;
    idle(2);

    f0 = frames;
    scan4(SEG_1, SEG_2, SEG_3, SEG_4);
    check("clean_frames", 32'(frames - f0), 32'd1);
    check("clean_value", 32'(bus.value), 32'h4321);
    check("clean_blank", 32'(bus.blank_mask), 32'h0);
    check("clean_err", 32'(bus.err_mask), 32'h0);

    f0   = frames;
    mon8 = 1'b1;
    show(4'b1110, SEG_8, 2);
    scan4(SEG_5, SEG_2, SEG_3, SEG_4);
    mon8 = 1'b0;
    check("glitch_frames", 32'(frames - f0), 32'd1);
    check("glitch_value", 32'(bus.value), 32'h4325);
    check("glitch_never8", 32'(bad8), 32'h0);

    f0 = frames;
    show(4'b1110, SEG_0, 6);
    show(4'b1101, SEG_9, 6);
    show(4'b1100, SEG_1, 10);
    check("inv_noframe", 32'(frames - f0), 32'd0);
    show(4'b1011, SEG_6, 6);
    show(4'b0111, SEG_7, 6);
    idle(4);
    check("inv_frames", 32'(frames - f0), 32'd1);
    check("inv_value", 32'(bus.value), 32'h7690);

    f0 = frames;
    scan4(SEG_3, SEG_4, SEG_BLANK, SEG_A);
    check("be_frames", 32'(frames - f0), 32'd1);
    check("be_blank", 32'(bus.blank_mask), 32'h4);
`ifdef SEVSEG_RD_HEXAF_EN
    check("be_err", 32'(bus.err_mask), 32'h0);
    check("be_value", 32'(bus.value), 32'hA043);
`else
    check("be_err", 32'(bus.err_mask), 32'h8);
    check("be_value", 32'(bus.value), 32'h0043);
`endif

    f0 = frames;
    show(4'b1110, SEG_0, 6);
    show(4'b1101, SEG_2, 6);
    show(4'b1110, SEG_7, 6);
    show(4'b1011, SEG_8, 6);
    show(4'b0111, SEG_5, 6);
    idle(4);
    check("ow_frames", 32'(frames - f0), 32'd1);
    check("ow_value", 32'(bus.value), 32'h5827);
    check("ow_err", 32'(bus.err_mask), 32'h0);

    show(4'b1110, SEG_1, 6);
    show(4'b1101, SEG_2, 6);
    show(4'b1011, SEG_3, 6);
    show(4'b0111, SEG_4, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_value", 32'(bus.value), 32'h0);
    check("mid_rst_blank", 32'(bus.blank_mask), 32'h0);
    check("mid_rst_err", 32'(bus.err_mask), 32'h0);
    check("mid_rst_fv", 32'(bus.frame_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    f0 = frames;
    show(4'b0111, SEG_4, 6);
    idle(4);
    check("post_rst_noframe", 32'(frames - f0), 32'd0);
    check("post_rst_value", 32'(bus.value), 32'h0);
    scan4(SEG_1, SEG_2, SEG_3, SEG_4);
    check("post_rst_frames", 32'(frames - f0), 32'd1);
    check("post_rst_full", 32'(bus.value), 32'h4321);
    check("fv_one_cycle", 32'(wide), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
